// File: rtl/pipeline_decode_if.sv
// Signal bundle between fetch/writeback (master side) and pipeline_decode (slave side).
interface pipeline_decode_if;
  // fetch stage
  logic [31:0] instruction_i;
  logic [31:0] pc_i;
  logic [31:0] pcsrc_i;
  logic        valid_i;
  logic        flush_i;
  // register-file write port from writeback
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  // hazard back-pressure towards fetch
  logic        stall_o;
  // ID/EX payload towards execute
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_pcsrc_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [4:0]  ex_rd_o;
  logic [6:0]  ex_opcode_o;
  logic [2:0]  ex_funct3_o;
  logic [6:0]  ex_funct7_o;
  logic        ex_mem_read_o;
  logic        ex_mem_write_o;
  logic        ex_reg_write_o;
  logic        ex_illegal_o;

  modport master (
    output instruction_i, pc_i, pcsrc_i, valid_i, flush_i,
    output wb_en_i, wb_rd_i, wb_data_i,
    input  stall_o,
    input  ex_valid_o, ex_pc_o, ex_pcsrc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
    input  ex_rs1_o, ex_rs2_o, ex_rd_o, ex_opcode_o, ex_funct3_o, ex_funct7_o,
    input  ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_illegal_o
  );

  modport slave (
    input  instruction_i, pc_i, pcsrc_i, valid_i, flush_i,
    input  wb_en_i, wb_rd_i, wb_data_i,
    output stall_o,
    output ex_valid_o, ex_pc_o, ex_pcsrc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
    output ex_rs1_o, ex_rs2_o, ex_rd_o, ex_opcode_o, ex_funct3_o, ex_funct7_o,
    output ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_illegal_o
  );
endinterface

// File: rtl/pipeline_decode.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-through
// bypass, instruction decode, load-use hazard detection and ID/EX register.
module pipeline_decode #(
  parameter int          XLEN      = 32,            // only 32 is supported
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk_i,
  input  logic             reset_i,   // asynchronous, active low
  pipeline_decode_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcsrc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            illegal;
  } idex_t;

  // IF/ID stage
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pcsrc_q, ifid_pcsrc_d;
  logic            ifid_valid_q, ifid_valid_d;

  // register file; entry 0 is never written
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  // ID/EX stage and the decode feeding it
  idex_t idex_q, idex_d, dec;

  // decoded fields of the IF/ID instruction
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic            legal, uses_rs1, uses_rs2, writes_rd, mem_rd, mem_wr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            hazard;

  assign opcode = ifid_instr_q[6:0];
  assign rd     = ifid_instr_q[11:7];
  assign funct3 = ifid_instr_q[14:12];
  assign rs1    = ifid_instr_q[19:15];
  assign rs2    = ifid_instr_q[24:20];
  assign funct7 = ifid_instr_q[31:25];

  assign imm_i = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
  assign imm_s = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
  assign imm_b = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                  ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
  assign imm_u = {ifid_instr_q[31:12], 12'b0};
  assign imm_j = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                  ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

  // Per-opcode control: legality, operand usage, immediate format, side effects
  always_comb begin
    legal     = 1'b1;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    imm       = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
        imm       = imm_u;
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        imm       = imm_j;
      end
      OPC_JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_i;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_b;
      end
      OPC_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        mem_rd    = 1'b1;
        imm       = imm_i;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        mem_wr   = 1'b1;
        imm      = imm_s;
      end
      OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_i;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Register reads: x0 is hard zero, a same-cycle writeback to the source wins
  assign rs1_data = (rs1 == 5'd0) ? '0 :
                    (bus.wb_en_i && bus.wb_rd_i == rs1) ? bus.wb_data_i : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 :
                    (bus.wb_en_i && bus.wb_rd_i == rs2) ? bus.wb_data_i : regs_q[rs2];

  // Load-use hazard: the load in ID/EX targets a source the IF/ID instruction reads
  assign hazard = ifid_valid_q && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  ((uses_rs1 && rs1 == idex_q.rd) || (uses_rs2 && rs2 == idex_q.rd));

  // A redirect makes holding fetch pointless, so flush masks the stall request
  assign bus.stall_o = hazard && !bus.flush_i;

  // Assemble the ID/EX payload for the instruction currently in IF/ID
  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.pc        = ifid_pc_q;
    dec.pcsrc     = ifid_pcsrc_q;
    dec.rs1_data  = rs1_data;
    dec.rs2_data  = rs2_data;
    dec.imm       = imm;
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.rd        = rd;
    dec.opcode    = opcode;
    dec.funct3    = funct3;
    dec.funct7    = funct7;
    dec.mem_read  = mem_rd;
    dec.mem_write = mem_wr;
    dec.reg_write = writes_rd && (rd != 5'd0);
    dec.illegal   = !legal;
  end

  // ID/EX next state: bubble on flush, hazard or empty IF/ID
  always_comb begin
    idex_d = '0;
    if (!bus.flush_i && !hazard && ifid_valid_q) begin
      idex_d = dec;
    end
  end

  // IF/ID next state: flush injects a NOP, hazard holds, otherwise load from fetch
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcsrc_d = ifid_pcsrc_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.flush_i) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_pcsrc_d = '0;
      ifid_valid_d = 1'b0;
    end else if (!hazard) begin
      ifid_instr_d = bus.instruction_i;
      ifid_pc_d    = bus.pc_i;
      ifid_pcsrc_d = bus.pcsrc_i;
      ifid_valid_d = bus.valid_i;
    end
  end

  // Register-file next state: writes to x0 are dropped
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.wb_en_i && bus.wb_rd_i != 5'd0) begin
      regs_d[bus.wb_rd_i] = bus.wb_data_i;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pcsrc_q <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcsrc_q <= ifid_pcsrc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
    end
  end

  // Register file storage, cleared by reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.ex_valid_o     = idex_q.valid;
  assign bus.ex_pc_o        = idex_q.pc;
  assign bus.ex_pcsrc_o     = idex_q.pcsrc;
  assign bus.ex_rs1_data_o  = idex_q.rs1_data;
  assign bus.ex_rs2_data_o  = idex_q.rs2_data;
  assign bus.ex_imm_o       = idex_q.imm;
  assign bus.ex_rs1_o       = idex_q.rs1;
  assign bus.ex_rs2_o       = idex_q.rs2;
  assign bus.ex_rd_o        = idex_q.rd;
  assign bus.ex_opcode_o    = idex_q.opcode;
  assign bus.ex_funct3_o    = idex_q.funct3;
  assign bus.ex_funct7_o    = idex_q.funct7;
  assign bus.ex_mem_read_o  = idex_q.mem_read;
  assign bus.ex_mem_write_o = idex_q.mem_write;
  assign bus.ex_reg_write_o = idex_q.reg_write;
  assign bus.ex_illegal_o   = idex_q.illegal;

endmodule

// File: tb/tb_pipeline_decode.sv
// Self-checking bench for pipeline_decode: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipeline_decode;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_decode_if bus();

  pipeline_decode #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcsrc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } ex_t;

  // model state: the instruction waiting in decode, the expected ID/EX contents, registers
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_pcsrc = 32'd0;
  logic        m_valid = 1'b0;
  ex_t         m_ex    = '0;
  logic        m_held  = 1'b0;
  logic [31:0] m_regs [32];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_ex(input string name, input ex_t act, input ex_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic logic reads_rs1(input logic [31:0] ins);
    return is_legal(ins[6:0]) && !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic reads_rs2(input logic [31:0] ins);
    return ins[6:0] inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic logic writes_reg(input logic [31:0] ins);
    return ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  endfunction

  // Immediates built arithmetically: sign part times a power of two plus the field pieces
  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int s;
    s = int'(ins);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
      7'h23: return 32'(s >>> 25) * 32'd32 + 32'(ins[11:7]);
      7'h63: return 32'(s >>> 31) * 32'd4096 + 32'(ins[7]) * 32'd2048
                    + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2;
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: return 32'(s >>> 31) * 32'h00100000 + 32'(ins[19:12]) * 32'd4096
                    + 32'(ins[20]) * 32'd2048 + 32'(ins[30:21]) * 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_en_i && bus.wb_rd_i == idx) return bus.wb_data_i;
    return m_regs[idx];
  endfunction

  function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] pcsrc);
    ex_t e;
    e           = '0;
    e.valid     = 1'b1;
    e.pc        = pc;
    e.pcsrc     = pcsrc;
    e.rs1       = ins[19:15];
    e.rs2       = ins[24:20];
    e.rd        = ins[11:7];
    e.rs1_data  = model_read(ins[19:15]);
    e.rs2_data  = model_read(ins[24:20]);
    e.imm       = imm_of(ins);
    e.opcode    = ins[6:0];
    e.funct3    = ins[14:12];
    e.funct7    = ins[31:25];
    e.illegal   = !is_legal(ins[6:0]);
    e.mem_read  = (ins[6:0] == 7'h03);
    e.mem_write = (ins[6:0] == 7'h23);
    e.reg_write = writes_reg(ins) && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic model_hazard();
    if (!(m_valid && m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd0)) return 1'b0;
    return (reads_rs1(m_instr) && m_instr[19:15] == m_ex.rd) ||
           (reads_rs2(m_instr) && m_instr[24:20] == m_ex.rd);
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.valid     = bus.ex_valid_o;
    e.pc        = bus.ex_pc_o;
    e.pcsrc     = bus.ex_pcsrc_o;
    e.rs1_data  = bus.ex_rs1_data_o;
    e.rs2_data  = bus.ex_rs2_data_o;
    e.imm       = bus.ex_imm_o;
    e.rs1       = bus.ex_rs1_o;
    e.rs2       = bus.ex_rs2_o;
    e.rd        = bus.ex_rd_o;
    e.opcode    = bus.ex_opcode_o;
    e.funct3    = bus.ex_funct3_o;
    e.funct7    = bus.ex_funct7_o;
    e.mem_read  = bus.ex_mem_read_o;
    e.mem_write = bus.ex_mem_write_o;
    e.reg_write = bus.ex_reg_write_o;
    e.illegal   = bus.ex_illegal_o;
    return e;
  endfunction

  // behavioural model: one transfer per clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_instr <= NOP;
      m_pc    <= 32'd0;
      m_pcsrc <= 32'd0;
      m_valid <= 1'b0;
      m_ex    <= '0;
      m_held  <= 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      m_held <= model_hazard() && !bus.flush_i;
      if (bus.flush_i) begin
        m_ex    <= '0;
        m_instr <= NOP;
        m_pc    <= 32'd0;
        m_pcsrc <= 32'd0;
        m_valid <= 1'b0;
      end else if (model_hazard()) begin
        m_ex <= '0;
      end else begin
        m_ex    <= m_valid ? model_decode(m_instr, m_pc, m_pcsrc) : '0;
        m_instr <= bus.instruction_i;
        m_pc    <= bus.pc_i;
        m_pcsrc <= bus.pcsrc_i;
        m_valid <= bus.valid_i;
      end
      if (bus.wb_en_i && bus.wb_rd_i != 5'd0) m_regs[bus.wb_rd_i] <= bus.wb_data_i;
    end
  end

  // compare process: every falling edge
  initial begin
    forever begin
      @(negedge clk);
      check32("stall_o", 32'(bus.stall_o), 32'(model_hazard() && !bus.flush_i));
      check_ex("id_ex", dut_ex(), m_ex);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    bus.instruction_i = ins;
    bus.pc_i          = pc;
    bus.pcsrc_i       = pc + 32'd4;
    bus.valid_i       = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    ins = $urandom;
    case ($urandom_range(0, 11))
      0:       return ins;
      1, 2, 3: op = 7'h03;
      4:       op = 7'h37;
      5:       op = 7'h17;
      6:       op = 7'h6F;
      7:       op = 7'h67;
      8:       op = 7'h63;
      9:       op = 7'h23;
      10:      op = 7'h13;
      default: op = 7'h33;
    endcase
    ins[6:0]   = op;
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    logic [31:0] pc;
    bus.instruction_i = NOP;
    bus.pc_i          = 32'd0;
    bus.pcsrc_i       = 32'd0;
    bus.valid_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.wb_en_i       = 1'b0;
    bus.wb_rd_i       = 5'd0;
    bus.wb_data_i     = 32'd0;
    step();
    step();
    check_ex("reset_outputs", dut_ex(), '0);
    check32("reset_stall", 32'(bus.stall_o), 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5 reaches ID/EX two edges after it is presented
    fetch(32'h00500093, 32'h0);
    step();
    bus.valid_i = 1'b0;
    step();
    check32("addi_valid", 32'(bus.ex_valid_o), 32'd1);
    check32("addi_rd", 32'(bus.ex_rd_o), 32'd1);
    check32("addi_imm", bus.ex_imm_o, 32'd5);
    check32("addi_regwrite", 32'(bus.ex_reg_write_o), 32'd1);

    // same-cycle writeback of x2 while add x3,x2,x0 is decoded
    fetch(32'h000101B3, 32'h4);
    step();
    bus.valid_i   = 1'b0;
    bus.wb_en_i   = 1'b1;
    bus.wb_rd_i   = 5'd2;
    bus.wb_data_i = 32'hDEADBEEF;
    step();
    bus.wb_en_i = 1'b0;
    check32("bypass_rs1_data", bus.ex_rs1_data_o, 32'hDEADBEEF);

    // lw x5,0(x1) then add x6,x5,x5: one stall, one bubble
    fetch(32'h0000A283, 32'h10);
    step();
    fetch(32'h00528333, 32'h14);
    step();
    check32("loaduse_stall", 32'(bus.stall_o), 32'd1);
    check32("loaduse_lw_memread", 32'(bus.ex_mem_read_o), 32'd1);
    step();
    check32("loaduse_bubble", 32'(bus.ex_valid_o), 32'd0);
    check32("loaduse_stall_done", 32'(bus.stall_o), 32'd0);
    bus.valid_i = 1'b0;
    step();
    check32("loaduse_add_valid", 32'(bus.ex_valid_o), 32'd1);
    check32("loaduse_add_rd", 32'(bus.ex_rd_o), 32'd6);

    // flush with both stages holding real instructions
    fetch(32'h00100113, 32'h100);
    step();
    fetch(32'h00200193, 32'h104);
    step();
    check32("flush_pre_valid", 32'(bus.ex_valid_o), 32'd1);
    fetch(32'h00300213, 32'h108);
    bus.flush_i = 1'b1;
    #1;
    check32("flush_stall", 32'(bus.stall_o), 32'd0);
    step();
    check32("flush_bubble1", 32'(bus.ex_valid_o), 32'd0);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    step();
    check32("flush_bubble2", 32'(bus.ex_valid_o), 32'd0);
    check32("flush_stall_after", 32'(bus.stall_o), 32'd0);

    // immediate formats and an illegal opcode
    fetch(32'hFE000EE3, 32'h200);
    step();
    fetch(32'h800000B7, 32'h204);
    step();
    check32("beq_imm", bus.ex_imm_o, 32'hFFFFFFFC);
    fetch(32'hFFFFFFFF, 32'h208);
    step();
    check32("lui_imm", bus.ex_imm_o, 32'h80000000);
    check32("lui_regwrite", 32'(bus.ex_reg_write_o), 32'd1);
    bus.valid_i = 1'b0;
    step();
    check32("illegal_flag", 32'(bus.ex_illegal_o), 32'd1);
    check32("illegal_valid", 32'(bus.ex_valid_o), 32'd1);
    check32("illegal_ctrl", {29'd0, bus.ex_mem_read_o, bus.ex_mem_write_o, bus.ex_reg_write_o},
            32'd0);

    // x0 stays zero, both stored and through the bypass path
    bus.wb_en_i   = 1'b1;
    bus.wb_rd_i   = 5'd0;
    bus.wb_data_i = 32'h00001234;
    fetch(32'h000001B3, 32'h300);
    step();
    bus.valid_i = 1'b0;
    step();
    bus.wb_en_i = 1'b0;
    check32("x0_read", bus.ex_rs1_data_o, 32'd0);

    // asynchronous reset while instructions are in flight
    fetch(32'h00500093, 32'h310);
    step();
    fetch(32'h000101B3, 32'h314);
    step();
    check32("pre_reset_valid", 32'(bus.ex_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_ex("async_reset_ex", dut_ex(), '0);
    check32("async_reset_stall", 32'(bus.stall_o), 32'd0);
    rst_n = 1'b1;
    fetch(32'h000101B3, 32'h400);
    step();
    bus.valid_i = 1'b0;
    step();
    check32("regs_cleared_x2", bus.ex_rs1_data_o, 32'd0);
    check32("post_reset_pc", bus.ex_pc_o, 32'h400);

    // reset asserted in the middle of a load-use stall
    fetch(32'h0000A283, 32'h500);
    step();
    fetch(32'h00528333, 32'h504);
    step();
    check32("midstall_stall", 32'(bus.stall_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check32("midstall_reset_stall", 32'(bus.stall_o), 32'd0);
    check_ex("midstall_reset_ex", dut_ex(), '0);
    rst_n = 1'b1;
    fetch(32'h00500093, 32'h600);
    step();
    bus.valid_i = 1'b0;
    step();
    check32("midstall_recover_valid", 32'(bus.ex_valid_o), 32'd1);
    check32("midstall_recover_pc", bus.ex_pc_o, 32'h600);

    // randomized traffic, checked every cycle by the compare process
    pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      if (!m_held) begin
        bus.instruction_i = rand_instr();
        bus.pc_i          = pc;
        bus.pcsrc_i       = pc + 32'd4;
        bus.valid_i       = ($urandom_range(0, 99) < 85);
        pc                = pc + 32'd4;
      end
      bus.flush_i   = ($urandom_range(0, 99) < 8);
      bus.wb_en_i   = ($urandom_range(0, 1) == 1);
      bus.wb_rd_i   = 5'($urandom_range(0, 7));
      bus.wb_data_i = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
